icache_refill: RTL and testbench

ICACHE_REFILL -- requirements
Module: icache_refill

---
 rtl/icache_refill.sv | 126 ++++++++++++
 tb/tb_icache_refill.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/icache_refill.sv
// Instruction-cache line refill: fetches 4 words from backing memory, writes tag/data to the victim way.
// Define ICACHE_REFILL_CRITICAL_FIRST_EN to fetch the missed word first (wrapping order).
module icache_refill #(
  parameter int ADDR_WIDTH = 6,
  parameter int TAG_WIDTH  = 8,
  parameter int DATA_WIDTH = 128,
  parameter int N_WAY      = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_cache_miss,
  input  logic [31:0]           i_addr_miss,
  input  logic [N_WAY-1:0]      i_vic_miss,
  output logic                  o_resp_miss,
  output logic                  o_mem_req,
  output logic [31:0]           o_mem_addr,
  input  logic                  i_mem_gnt,
  input  logic                  i_mem_rvalid,
  input  logic [31:0]           i_mem_rdata,
  output logic [N_WAY-1:0]      o_tag_wren,
  output logic [ADDR_WIDTH-1:0] o_tag_waddr,
  output logic [TAG_WIDTH-1:0]  o_tag_wdata,
  output logic [N_WAY-1:0]      o_data_wren,
  output logic [DATA_WIDTH-1:0] o_data_wdata,
  output logic                  o_busy
);

  // state | meaning
  // IDLE  | waiting for a miss
  // FETCH | issuing word reads and collecting responses
  // WRITE | one-cycle tag/data write to the victim way
  // RESP  | one-cycle completion pulse
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

`ifdef ICACHE_REFILL_CRITICAL_FIRST_EN
  localparam logic CRIT_FIRST = 1'b1;
`else
  localparam logic CRIT_FIRST = 1'b0;
`endif

  logic [1:0]            r_state;
  logic [31:0]           r_addr;
  logic [N_WAY-1:0]      r_vic;
  logic [2:0]            r_req_cnt;
  logic [2:0]            r_rsp_cnt;
  logic [DATA_WIDTH-1:0] r_line;

  logic [N_WAY-1:0] w_vic_dec;
  logic             w_vic_found;
  logic [1:0]       w_start;
  logic [1:0]       w_req_word;
  logic [1:0]       w_rsp_word;
  logic             w_fetch;
  logic             w_write;
  logic             w_gnt_ok;
  logic             w_rsp_ok;

  // Lowest set bit wins; an empty victim vector falls back to way 0.
  always_comb begin
    w_vic_dec   = '0;
    w_vic_found = 1'b0;
    for (int i = 0; i < N_WAY; i++) begin
      if (i_vic_miss[i] && !w_vic_found) begin
        w_vic_dec[i] = 1'b1;
        w_vic_found  = 1'b1;
      end
    end
    if (!w_vic_found) w_vic_dec[0] = 1'b1;
  end

  assign w_start    = CRIT_FIRST ? r_addr[1:0] : 2'd0;
  assign w_req_word = w_start + r_req_cnt[1:0];
  assign w_rsp_word = w_start + r_rsp_cnt[1:0];
  assign w_fetch    = (r_state == S_FETCH);
  assign w_write    = (r_state == S_WRITE);
  assign w_gnt_ok   = o_mem_req && i_mem_gnt;
  // Only responses backed by a granted, unanswered request are accepted.
  assign w_rsp_ok   = w_fetch && i_mem_rvalid && (r_rsp_cnt < r_req_cnt);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_vic     <= '0;
      r_req_cnt <= '0;
      r_rsp_cnt <= '0;
      r_line    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_cache_miss) begin
            r_addr    <= i_addr_miss;
            r_vic     <= w_vic_dec;
            r_req_cnt <= '0;
            r_rsp_cnt <= '0;
            r_state   <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (w_gnt_ok) r_req_cnt <= r_req_cnt + 3'd1;
          if (w_rsp_ok) begin
            r_line[32*w_rsp_word +: 32] <= i_mem_rdata;
            r_rsp_cnt <= r_rsp_cnt + 3'd1;
            if (r_rsp_cnt == 3'd3) r_state <= S_WRITE;
          end
        end
        S_WRITE: r_state <= S_RESP;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy       = (r_state != S_IDLE);
  assign o_resp_miss  = (r_state == S_RESP);
  assign o_mem_req    = w_fetch && !r_req_cnt[2];
  assign o_mem_addr   = w_fetch ? {r_addr[31:2], w_req_word} : 32'd0;
  assign o_tag_wren   = w_write ? r_vic : '0;
  assign o_data_wren  = w_write ? r_vic : '0;
  assign o_tag_waddr  = w_write ? r_addr[2 +: ADDR_WIDTH] : '0;
  assign o_tag_wdata  = w_write ? {1'b1, r_addr[2+ADDR_WIDTH +: TAG_WIDTH-1]} : '0;
  assign o_data_wdata = w_write ? r_line : '0;

endmodule

// File: tb/tb_icache_refill.sv
// Self-checking bench for icache_refill: vector table, corner sequences, randomized memory timing.
module tb_icache_refill;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         i_cache_miss = 1'b0;
  logic [31:0]  i_addr_miss = '0;
  logic [3:0]   i_vic_miss = '0;
  logic         o_resp_miss;
  logic         o_mem_req;
  logic [31:0]  o_mem_addr;
  logic         i_mem_gnt = 1'b0;
  logic         i_mem_rvalid = 1'b0;
  logic [31:0]  i_mem_rdata = '0;
  logic [3:0]   o_tag_wren;
  logic [5:0]   o_tag_waddr;
  logic [7:0]   o_tag_wdata;
  logic [3:0]   o_data_wren;
  logic [127:0] o_data_wdata;
  logic         o_busy;

  icache_refill dut (
    .i_clk(clk), .i_rst(rst),
    .i_cache_miss(i_cache_miss), .i_addr_miss(i_addr_miss), .i_vic_miss(i_vic_miss),
    .o_resp_miss(o_resp_miss), .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr),
    .i_mem_gnt(i_mem_gnt), .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata),
    .o_tag_wren(o_tag_wren), .o_tag_waddr(o_tag_waddr), .o_tag_wdata(o_tag_wdata),
    .o_data_wren(o_data_wren), .o_data_wdata(o_data_wdata), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

`ifdef ICACHE_REFILL_CRITICAL_FIRST_EN
  localparam bit CRIT = 1'b1;
`else
  localparam bit CRIT = 1'b0;
`endif

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_data(input logic [31:0] a, input logic [31:0] seed);
    return (a * 3) ^ seed;
  endfunction

  task automatic chk_all_zero(input string name);
    chk(name, {o_resp_miss, o_mem_req, o_mem_addr, o_tag_wren, o_tag_waddr,
               o_tag_wdata, o_data_wren, o_busy}, '0);
    chk({name, "_line"}, o_data_wdata, '0);
  endtask

  // Caller must be at a falling edge; the miss is sampled at the next rising edge (cycle 0).
  task automatic run_miss(input logic [31:0] addr, input logic [3:0] vic, input int gnt_wait,
                          input int lat_min, input int lat_max, input bit spurious,
                          input logic [31:0] seed, input int abort_after, input bit second_miss,
                          output int resp_cycle, output logic [3:0] wren_seen,
                          output logic [5:0] idx_seen, output logic [7:0] tag_seen);
    logic [31:0]  exp_addr[4];
    logic [31:0]  pend_a[$];
    int           pend_due[$];
    logic [127:0] exp_line;
    logic [1:0]   start;
    int gcnt, rcnt, wait_ctr, last_rv, wren_cycle, exp_way;
    bit done, g;
    gcnt = 0; rcnt = 0; wait_ctr = 0; last_rv = -1; wren_cycle = -1; done = 0;
    resp_cycle = -1; wren_seen = '0; idx_seen = '0; tag_seen = '0;
    start = CRIT ? addr[1:0] : 2'd0;
    for (int k = 0; k < 4; k++) exp_addr[k] = {addr[31:2], 2'(int'(start) + k)};
    for (int w = 0; w < 4; w++) exp_line[32*w +: 32] = mem_data({addr[31:2], 2'(w)}, seed);
    exp_way = 0;
    for (int i = 3; i >= 0; i--) if (vic[i]) exp_way = i;

    i_cache_miss = 1'b1; i_addr_miss = addr; i_vic_miss = vic;
    @(negedge clk);
    for (int c = 1; c <= 400; c++) begin
      if (abort_after > 0 && rcnt == abort_after && last_rv < c) begin
        rst = 1'b1; i_cache_miss = 1'b0; i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0;
        #1;
        chk_all_zero("abort_outputs");
        for (int r = 0; r < 3; r++) begin
          @(negedge clk);
          chk("abort_no_resp", {o_resp_miss, o_tag_wren, o_data_wren, o_busy}, '0);
        end
        rst = 1'b0;
        return;
      end
      if (second_miss && c == 2) begin
        i_cache_miss = 1'b1; i_addr_miss = ~addr; i_vic_miss = 4'b1000;
      end else begin
        i_cache_miss = 1'b0;
      end

      chk("busy", o_busy, 1'b1);
      chk("mem_req", o_mem_req, gcnt < 4);
      if (o_mem_req && gcnt < 4) chk("mem_addr", o_mem_addr, exp_addr[gcnt]);

      i_mem_gnt = 1'b0;
      if (o_mem_req && gcnt < 4) begin
        if (gnt_wait < 0) g = ($urandom_range(0, 1) == 1);
        else              g = (wait_ctr >= gnt_wait);
        if (g) begin
          i_mem_gnt = 1'b1;
          pend_a.push_back(exp_addr[gcnt]);
          pend_due.push_back(c + int'($urandom_range(lat_min, lat_max)));
          gcnt++;
          wait_ctr = 0;
        end else begin
          wait_ctr++;
        end
      end

      i_mem_rvalid = 1'b0;
      i_mem_rdata  = $urandom;
      if (pend_a.size() > 0 && pend_due[0] <= c) begin
        i_mem_rvalid = 1'b1;
        i_mem_rdata  = mem_data(pend_a.pop_front(), seed);
        void'(pend_due.pop_front());
        rcnt++;
        last_rv = c;
      end else if (spurious && pend_a.size() == 0 && $urandom_range(0, 3) == 0) begin
        i_mem_rvalid = 1'b1;
      end

      if (o_tag_wren != 0 || o_data_wren != 0) begin
        wren_cycle = c;
        wren_seen = o_tag_wren; idx_seen = o_tag_waddr; tag_seen = o_tag_wdata;
        chk("tag_wren", o_tag_wren, 4'b1 << exp_way);
        chk("data_wren", o_data_wren, 4'b1 << exp_way);
        chk("tag_waddr", o_tag_waddr, addr[7:2]);
        chk("tag_wdata", o_tag_wdata, {1'b1, addr[14:8]});
        chk("line", o_data_wdata, exp_line);
        chk("wren_cycle", wren_cycle, last_rv + 1);
        chk("resp_with_wren", o_resp_miss, 1'b0);
      end
      if (o_resp_miss) begin
        resp_cycle = c;
        done = 1;
        chk("resp_cycle", c, last_rv + 2);
        break;
      end
      @(negedge clk);
    end
    chk("refill_done", done, 1'b1);
    i_cache_miss = 1'b0; i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0;
    for (int r = 0; r < 3; r++) begin
      @(negedge clk);
      chk("idle_after", {o_resp_miss, o_mem_req, o_tag_wren, o_data_wren, o_busy}, '0);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  vic;
    int          gnt_wait;
    int          lat;
    logic [3:0]  exp_wren;
    logic [5:0]  exp_idx;
    logic [7:0]  exp_tagw;
    int          exp_resp;
  } vec_t;

  vec_t vecs[6];
  int resp_c;
  logic [3:0] wren_s;
  logic [5:0] idx_s;
  logic [7:0] tag_s;

  initial begin
    vecs[0] = '{32'h0000_00A5, 4'b0100, 0, 1, 4'b0100, 6'h29, 8'h80, 7};
    vecs[1] = '{32'h0000_00A5, 4'b0000, 0, 1, 4'b0001, 6'h29, 8'h80, 7};
    vecs[2] = '{32'h1234_5678, 4'b1010, 0, 1, 4'b0010, 6'h1E, 8'hD6, 7};
    vecs[3] = '{32'h0000_00A5, 4'b1000, 3, 1, 4'b1000, 6'h29, 8'h80, 19};
    vecs[4] = '{32'hFFFF_FFFF, 4'b1111, 1, 2, 4'b0001, 6'h3F, 8'hFF, 12};
    vecs[5] = '{32'h0000_0302, 4'b0010, 0, 3, 4'b0010, 6'h00, 8'h83, 9};

    repeat (2) @(negedge clk);
    chk_all_zero("reset_outputs");
    rst = 1'b0;

    for (int v = 0; v < 6; v++) begin
      run_miss(vecs[v].addr, vecs[v].vic, vecs[v].gnt_wait, vecs[v].lat, vecs[v].lat,
               1'b0, 32'd0, 0, 1'b0, resp_c, wren_s, idx_s, tag_s);
      chk("vec_resp", resp_c, vecs[v].exp_resp);
      chk("vec_wren", wren_s, vecs[v].exp_wren);
      chk("vec_idx", idx_s, vecs[v].exp_idx);
      chk("vec_tagw", tag_s, vecs[v].exp_tagw);
    end

    // Second miss while busy must be dropped.
    run_miss(32'h0000_0C3C, 4'b0001, 0, 1, 1, 1'b0, 32'h5A5A_0000, 0, 1'b1,
             resp_c, wren_s, idx_s, tag_s);
    chk("dup_miss_resp", resp_c, 7);
    chk("dup_miss_wren", wren_s, 4'b0001);

    // Reset after the second response, then a miss on the first edge after release.
    run_miss(32'h0000_00A5, 4'b0100, 0, 1, 1, 1'b0, 32'd0, 2, 1'b0,
             resp_c, wren_s, idx_s, tag_s);
    run_miss(32'h0000_00A5, 4'b0100, 0, 1, 1, 1'b0, 32'd0, 0, 1'b0,
             resp_c, wren_s, idx_s, tag_s);
    chk("post_reset_resp", resp_c, 7);
    chk("post_reset_wren", wren_s, 4'b0100);

    for (int n = 0; n < 25; n++) begin
      run_miss($urandom, 4'($urandom_range(0, 15)), -1, 1, 3, 1'b1, $urandom, 0, 1'b0,
               resp_c, wren_s, idx_s, tag_s);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
